// File: rtl/gcd_job_sequencer.sv
// Queues operand pairs in a small FIFO and runs them one at a time through an external gcd core,
// holding each result (with its operands and RUN-cycle count) until the consumer accepts it.
module gcd_job_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         core_rst,
  output logic [W-1:0] core_a,
  output logic [W-1:0] core_b,
  input  logic [W-1:0] core_ret,
  input  logic         core_done,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_ret,
  output logic [W-1:0] out_a,
  output logic [W-1:0] out_b,
  output logic [15:0]  out_cycles,
  output logic         busy
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StLaunch, StRun, StHold} state_e;

  state_e        state;
  logic [W-1:0]  fifo_a [DEPTH];
  logic [W-1:0]  fifo_b [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [W-1:0]  job_a;
  logic [W-1:0]  job_b;
  logic [15:0]   run_cnt;
  logic [15:0]   cnt_inc;

  always_comb begin
    full     = (count == DEPTH[AW:0]);
    empty    = (count == '0);
    in_ready = !full;
    push     = in_valid && in_ready;
    pop      = !empty && ((state == StIdle) || ((state == StHold) && out_ready));
    cnt_inc  = (run_cnt == 16'hFFFF) ? run_cnt : run_cnt + 16'd1;
    core_rst = rst || (state == StLaunch);
    core_a   = job_a;
    core_b   = job_b;
    busy     = (state != StIdle) || !empty;
  end

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a[wr_ptr] <= in_a;
      fifo_b[wr_ptr] <= in_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      job_a      <= '0;
      job_b      <= '0;
      run_cnt    <= '0;
      out_valid  <= 1'b0;
      out_ret    <= '0;
      out_a      <= '0;
      out_b      <= '0;
      out_cycles <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (pop) begin
            job_a   <= fifo_a[rd_ptr];
            job_b   <= fifo_b[rd_ptr];
            run_cnt <= '0;
            state   <= StLaunch;
          end
        end
        StLaunch: state <= StRun;
        StRun: begin
          run_cnt <= cnt_inc;
          // core_done is only trusted here; a stale done lingers through LAUNCH.
          if (core_done) begin
            out_ret    <= core_ret;
            out_a      <= job_a;
            out_b      <= job_b;
            out_cycles <= cnt_inc;
            out_valid  <= 1'b1;
            state      <= StHold;
          end
        end
        StHold: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (pop) begin
              job_a   <= fifo_a[rd_ptr];
              job_b   <= fifo_b[rd_ptr];
              run_cnt <= '0;
              state   <= StLaunch;
            end else begin
              state <= StIdle;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Directed bench for gcd_job_sequencer with a behavioural Euclid core attached to the core port.
module tb_gcd_job_sequencer;

  typedef struct packed {
    logic [7:0]  ret;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] cyc;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        core_rst;
  logic [7:0]  core_a;
  logic [7:0]  core_b;
  logic [7:0]  core_ret;
  logic        core_done;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_ret;
  logic [7:0]  out_a;
  logic [7:0]  out_b;
  logic [15:0] out_cycles;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;
  int launches    = 0;
  int l0;
  res_t res_q[$];

  always #5 clk = ~clk;

  gcd_job_sequencer #(.DEPTH(4), .W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .core_rst   (core_rst),
    .core_a     (core_a),
    .core_b     (core_b),
    .core_ret   (core_ret),
    .core_done  (core_done),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ret    (out_ret),
    .out_a      (out_a),
    .out_b      (out_b),
    .out_cycles (out_cycles),
    .busy       (busy)
  );

  // Core model: latches operands in reset and START cycles, then one Euclid step per cycle.
  logic [7:0] cx, cy, cret_q;
  logic [1:0] cph;
  logic       cdone_q;
  logic       stall = 1'b0;

  always @(posedge clk) begin
    if (core_rst) begin
      cx <= core_a; cy <= core_b; cdone_q <= 1'b0; cph <= 2'd1;
    end else if (cph == 2'd1) begin
      cx <= core_a; cy <= core_b; cph <= 2'd2;
    end else if (cph == 2'd2) begin
      if (cy == 8'd0) begin
        cdone_q <= 1'b1; cret_q <= cx; cph <= 2'd3;
      end else begin
        cx <= cy; cy <= cx % cy;
      end
    end
  end

  assign core_ret  = cret_q;
  assign core_done = cdone_q && !stall;

  always @(posedge clk)
    if (!rst && out_valid && out_ready)
      res_q.push_back(res_t'({out_ret, out_a, out_b, out_cycles}));

  always @(negedge clk)
    if (!rst && core_rst) launches++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b);
    logic acc;
    acc = 1'b0;
    in_a = a; in_b = b; in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      acc = in_ready;
      @(negedge clk);
      if (acc) break;
    end
    in_valid = 1'b0;
    check("push_accepted", 32'(acc), 32'd1);
  endtask

  task automatic wait_results(input string tag, input int n);
    for (int i = 0; i < 500 && res_q.size() < n; i++) @(negedge clk);
    check(tag, 32'(res_q.size()), 32'(n));
  endtask

  task automatic expect_res(input string tag, input logic [7:0] ret, input logic [7:0] a,
                            input logic [7:0] b, input int cyc);
    res_t r;
    r = '0;
    if (res_q.size() > 0) r = res_q.pop_front();
    check({tag, "_ret"}, 32'(r.ret), 32'(ret));
    check({tag, "_a"}, 32'(r.a), 32'(a));
    check({tag, "_b"}, 32'(r.b), 32'(b));
    if (cyc >= 0) check({tag, "_cyc"}, 32'(r.cyc), 32'(cyc));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset with in_valid asserted: nothing may be accepted.
    rst = 1'b1; in_valid = 1'b1; in_a = 8'd1; in_b = 8'd1; out_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    check("rst_core_rst", 32'(core_rst), 32'd1);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_ret", 32'(out_ret), 32'd0);
    check("reset_out_cycles", 32'(out_cycles), 32'd0);
    check("reset_core_rst", 32'(core_rst), 32'd0);
    check("reset_core_a", 32'(core_a), 32'd0);

    // (48,18): two-cycle latency to core_rst, single launch pulse.
    in_a = 8'd48; in_b = 8'd18; in_valid = 1'b1;
    check("lat_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("lat_idle_core_rst", 32'(core_rst), 32'd0);
    check("lat_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("lat_launch_core_rst", 32'(core_rst), 32'd1);
    check("lat_core_a", 32'(core_a), 32'd48);
    check("lat_core_b", 32'(core_b), 32'd18);
    @(negedge clk);
    check("lat_run_core_rst", 32'(core_rst), 32'd0);
    check("lat_run_core_a", 32'(core_a), 32'd48);
    wait_results("res_48_18", 1);
    expect_res("g48_18", 8'd6, 8'd48, 8'd18, 6);
    check("one_launch", 32'(launches), 32'd1);

    // Zero operands.
    push(8'd7, 8'd0);
    push(8'd0, 8'd5);
    push(8'd0, 8'd0);
    wait_results("res_zero", 3);
    expect_res("g7_0", 8'd7, 8'd7, 8'd0, 3);
    expect_res("g0_5", 8'd5, 8'd0, 8'd5, 4);
    expect_res("g0_0", 8'd0, 8'd0, 8'd0, 3);

    // Back-pressure: one in flight plus DEPTH queued fills the sequencer.
    out_ready = 1'b0;
    push(8'd9, 8'd6);
    push(8'd10, 8'd4);
    push(8'd21, 8'd14);
    push(8'd17, 8'd5);
    push(8'd100, 8'd75);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_busy", 32'(busy), 32'd1);
    repeat (5) @(negedge clk);
    check("full_in_ready_hold", 32'(in_ready), 32'd0);
    check("full_no_results", 32'(res_q.size()), 32'd0);
    out_ready = 1'b1;
    push(8'd30, 8'd12);
    wait_results("res_full", 6);
    expect_res("bp0", 8'd3, 8'd9, 8'd6, -1);
    expect_res("bp1", 8'd2, 8'd10, 8'd4, -1);
    expect_res("bp2", 8'd7, 8'd21, 8'd14, -1);
    expect_res("bp3", 8'd1, 8'd17, 8'd5, -1);
    expect_res("bp4", 8'd25, 8'd100, 8'd75, -1);
    expect_res("bp5", 8'd6, 8'd30, 8'd12, -1);

    // Hold a result for 10 cycles.
    out_ready = 1'b0;
    push(8'd255, 8'd15);
    for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
    check("hold_valid_seen", 32'(out_valid), 32'd1);
    l0 = launches;
    repeat (10) begin
      @(negedge clk);
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_out_ret", 32'(out_ret), 32'd15);
      check("hold_out_a", 32'(out_a), 32'd255);
      check("hold_out_b", 32'(out_b), 32'd15);
      check("hold_out_cycles", 32'(out_cycles), 32'd4);
      check("hold_core_rst", 32'(core_rst), 32'd0);
    end
    check("hold_no_launch", 32'(launches), 32'(l0));
    out_ready = 1'b1;
    wait_results("res_hold", 1);
    expect_res("g255_15", 8'd15, 8'd255, 8'd15, 4);

    // Reset mid-RUN with two pairs queued; stalled core also shows there is no timeout.
    stall = 1'b1;
    push(8'd50, 8'd20);
    push(8'd33, 8'd11);
    push(8'd44, 8'd4);
    repeat (20) @(negedge clk);
    check("stall_out_valid", 32'(out_valid), 32'd0);
    check("stall_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_core_rst", 32'(core_rst), 32'd1);
    rst = 1'b0; stall = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_cycles", 32'(out_cycles), 32'd0);
    l0 = launches;
    repeat (20) @(negedge clk);
    check("midrst_no_launch", 32'(launches), 32'(l0));
    check("midrst_no_results", 32'(res_q.size()), 32'd0);
    push(8'd12, 8'd8);
    wait_results("res_after_rst", 1);
    expect_res("g12_8", 8'd4, 8'd12, 8'd8, 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
